// File: rtl/spi_master_arbiter_if.sv
// Bundle of requester-side and SPI-driver-side signals around spi_master_arbiter.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface spi_master_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_bi;
   logic [NUM_REQ-1:0]   lock_bi;
   logic [NUM_REQ*8-1:0] data_in_bi;
   logic [NUM_REQ-1:0]   gnt_bo;
   logic [NUM_REQ-1:0]   done_bo;
   logic [NUM_REQ-1:0]   err_bo;
   logic [7:0]           data_out_bo;
   logic                 busy_o;
   logic                 m_start_o;
   logic [7:0]           m_data_o;
   logic                 m_ready_i;
   logic [7:0]           m_data_i;

   modport master (
      input  req_bi, lock_bi, data_in_bi, m_ready_i, m_data_i,
      output gnt_bo, done_bo, err_bo, data_out_bo, busy_o, m_start_o, m_data_o
   );

   modport slave (
      output req_bi, lock_bi, data_in_bi, m_ready_i, m_data_i,
      input  gnt_bo, done_bo, err_bo, data_out_bo, busy_o, m_start_o, m_data_o
   );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master driver between NUM_REQ byte requesters,
// with per-requester lock for back-to-back bursts and a start-acknowledge timeout.
module spi_master_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   spi_master_arbiter_if.master bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_owner;
   logic [CNT_W-1:0]   r_cnt;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] r_done;
   logic [NUM_REQ-1:0] r_err;
   logic [7:0]         r_data_out;
   logic [7:0]         r_m_data;
   logic               r_busy;
   logic               r_m_start;

   logic               w_found;
   logic [IDX_W-1:0]   w_idx;
   logic [IDX_W-1:0]   w_winner;
   logic [NUM_REQ-1:0] w_winner_oh;

   // Scan starts just after the last owner, so it has the lowest priority next.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      w_found     = 1'b0;
      w_idx       = r_ptr;
      w_winner    = r_ptr;
      w_winner_oh = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
         if (!w_found && bus.req_bi[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
      w_winner_oh[w_winner] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      if (!rst_n_i) begin
         r_state    <= S_IDLE;
         r_ptr      <= IDX_W'(NUM_REQ - 1);
         r_owner    <= '0;
         r_cnt      <= '0;
         r_gnt      <= '0;
         r_done     <= '0;
         r_err      <= '0;
         r_data_out <= '0;
         r_m_data   <= '0;
         r_busy     <= 1'b0;
         r_m_start  <= 1'b0;
      end else begin
         r_m_start <= 1'b0;
         r_done    <= '0;
         r_err     <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found && bus.m_ready_i) begin
                  r_gnt    <= w_winner_oh;
                  r_owner  <= w_winner;
                  r_m_data <= bus.data_in_bi[{w_winner, 3'b000} +: 8];
                  r_busy   <= 1'b1;
                  r_state  <= S_START;
               end
            end
            S_START: begin
               r_m_start <= 1'b1;
               r_cnt     <= '0;
               r_state   <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (!bus.m_ready_i) begin
                  r_state <= S_WAIT_DONE;
               end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                  // The master never acknowledged the start: give up on this transfer.
                  r_err   <= r_gnt;
                  r_gnt   <= '0;
                  r_ptr   <= r_owner;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (bus.m_ready_i) begin
                  r_data_out <= bus.m_data_i;
                  r_done     <= r_gnt;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.lock_bi[r_owner] && bus.req_bi[r_owner]) begin
                  r_m_data <= bus.data_in_bi[{r_owner, 3'b000} +: 8];
                  r_state  <= S_START;
               end else begin
                  r_ptr   <= r_owner;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.gnt_bo      = r_gnt;
   assign bus.done_bo     = r_done;
   assign bus.err_bo      = r_err;
   assign bus.data_out_bo = r_data_out;
   assign bus.busy_o      = r_busy;
   assign bus.m_start_o   = r_m_start;
   assign bus.m_data_o    = r_m_data;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: a cycle model of the arbitration rules plus a
// byte-swapping SPI driver stand-in, compared every cycle, with directed scenarios.
module tb_spi_master_arbiter;
   localparam int N  = 4;
   localparam int TO = 16;

   localparam int W_GNT   = 0;
   localparam int W_START = 1;
   localparam int W_DONE  = 2;
   localparam int W_ERR   = 3;

   // Phases of one transfer as seen from the requester side.
   localparam int PH_FREE   = 0;
   localparam int PH_ARMED  = 1;
   localparam int PH_ACKWT  = 2;
   localparam int PH_XFER   = 3;
   localparam int PH_HANDOF = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_master_arbiter_if #(.NUM_REQ(N)) bus ();

   spi_master_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(TO)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int         mdl_ptr, mdl_phase, mdl_owner, mdl_wait;
   logic [3:0] e_gnt, e_done, e_err;
   logic [7:0] e_dout, e_mdata;
   logic       e_busy, e_start;

   int         slave_mode;   // 0: normal driver, 1: ready tied high, 2: ready held low
   int         sl_cnt;
   logic [7:0] sl_resp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input int p, input logic [N-1:0] r);
      for (int i = 1; i <= N; i++) begin
         if (((r >> ((p + i) % N)) & 4'd1) != 4'd0) return (p + i) % N;
      end
      return -1;
   endfunction

   function automatic logic [7:0] req_byte(input int k);
      return 8'(bus.data_in_bi >> (8 * k));
   endfunction

   function automatic logic [7:0] swap(input logic [7:0] b);
      return {b[3:0], b[7:4]};
   endfunction

   // Expected registered outputs after this edge, from the inputs present at it.
   task automatic model_step();
      int w;
      e_start = 1'b0;
      e_done  = '0;
      e_err   = '0;
      if (!rst_n) begin
         mdl_phase = PH_FREE;
         mdl_ptr   = N - 1;
         mdl_owner = 0;
         mdl_wait  = 0;
         e_gnt     = '0;
         e_dout    = '0;
         e_mdata   = '0;
         e_busy    = 1'b0;
         return;
      end
      case (mdl_phase)
         PH_FREE: begin
            w = rr_pick(mdl_ptr, bus.req_bi);
            if (w >= 0 && bus.m_ready_i) begin
               mdl_owner = w;
               e_gnt     = 4'(1 << w);
               e_mdata   = req_byte(w);
               e_busy    = 1'b1;
               mdl_phase = PH_ARMED;
            end
         end
         PH_ARMED: begin
            e_start   = 1'b1;
            mdl_wait  = 0;
            mdl_phase = PH_ACKWT;
         end
         PH_ACKWT: begin
            if (!bus.m_ready_i) mdl_phase = PH_XFER;
            else begin
               mdl_wait++;
               if (mdl_wait == TO) begin
                  e_err     = e_gnt;
                  e_gnt     = '0;
                  e_busy    = 1'b0;
                  mdl_ptr   = mdl_owner;
                  mdl_phase = PH_FREE;
               end
            end
         end
         PH_XFER: begin
            if (bus.m_ready_i) begin
               e_dout    = bus.m_data_i;
               e_done    = e_gnt;
               mdl_phase = PH_HANDOF;
            end
         end
         default: begin
            if ((((bus.lock_bi & bus.req_bi) >> mdl_owner) & 4'd1) != 4'd0) begin
               e_mdata   = req_byte(mdl_owner);
               mdl_phase = PH_ARMED;
            end else begin
               e_gnt     = '0;
               e_busy    = 1'b0;
               mdl_ptr   = mdl_owner;
               mdl_phase = PH_FREE;
            end
         end
      endcase
   endtask

   // Stand-in SPI driver: drops ready after a start, answers with the nibble-swapped byte.
   task automatic slave_step();
      if (slave_mode == 1) bus.m_ready_i = 1'b1;
      else if (slave_mode == 2) bus.m_ready_i = 1'b0;
      else if (sl_cnt > 0) begin
         sl_cnt--;
         if (sl_cnt == 0) begin
            bus.m_data_i  = sl_resp;
            bus.m_ready_i = 1'b1;
         end
      end else if (bus.m_start_o) begin
         bus.m_ready_i = 1'b0;
         sl_cnt        = 3;
         sl_resp       = swap(bus.m_data_o);
      end else bus.m_ready_i = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("cycle_outputs",
            {2'b00, bus.gnt_bo, bus.done_bo, bus.err_bo, bus.data_out_bo,
             bus.busy_o, bus.m_start_o, bus.m_data_o},
            {2'b00, e_gnt, e_done, e_err, e_dout, e_busy, e_start, e_mdata});
      slave_step();
   endtask

   function automatic bit seen(input int what);
      case (what)
         W_GNT:   return (|bus.gnt_bo) === 1'b1;
         W_START: return bus.m_start_o === 1'b1;
         W_DONE:  return (|bus.done_bo) === 1'b1;
         default: return (|bus.err_bo) === 1'b1;
      endcase
   endfunction

   task automatic wait_for(input int what);
      for (int i = 0; i < 64; i++) begin
         if (seen(what)) return;
         tick();
      end
      check($sformatf("wait_event%0d", what), 32'(seen(what)), 32'd1);
   endtask

   function automatic logic [31:0] all_outs();
      return {2'b00, bus.gnt_bo, bus.done_bo, bus.err_bo, bus.data_out_bo,
              bus.busy_o, bus.m_start_o, bus.m_data_o};
   endfunction

   initial begin
      int         rr_order [5] = '{0, 1, 2, 3, 0};
      logic [7:0] rr_rx    [5] = '{8'h1E, 8'h2B, 8'h3C, 8'h4A, 8'h1E};
      logic [7:0] lk_bytes [3] = '{8'hFF, 8'hFF, 8'h00};
      bit         gap_seen;
      bit         done_seen;
      int         n;

      rst_n          = 1'b0;
      bus.req_bi     = '0;
      bus.lock_bi    = '0;
      bus.data_in_bi = '0;
      bus.m_ready_i  = 1'b1;
      bus.m_data_i   = '0;
      slave_mode     = 0;
      sl_cnt         = 0;
      sl_resp        = '0;
      mdl_ptr = N - 1; mdl_phase = PH_FREE; mdl_owner = 0; mdl_wait = 0;
      e_gnt = '0; e_done = '0; e_err = '0; e_dout = '0; e_mdata = '0;
      e_busy = 1'b0; e_start = 1'b0;

      @(negedge clk);
      tick();
      tick();
      check("reset_outputs", all_outs(), 32'h0);
      rst_n = 1'b1;
      tick();

      // Round-robin with all four requesting
      bus.data_in_bi = 32'hA4C3B2E1;
      bus.req_bi     = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         wait_for(W_GNT);
         check($sformatf("rr_grant%0d", t), 32'(bus.gnt_bo), 32'(1 << rr_order[t]));
         wait_for(W_DONE);
         check($sformatf("rr_rx%0d", t), 32'(bus.data_out_bo), 32'(rr_rx[t]));
         if (t == 4) bus.req_bi = '0;
         tick();
         check($sformatf("rr_gap%0d", t), 32'(bus.gnt_bo), 32'h0);
      end

      // Basic transfer, TX byte changed after capture
      bus.data_in_bi[7:0] = 8'h35;
      bus.req_bi          = 4'b0001;
      tick();
      check("basic_gnt", 32'({bus.gnt_bo, bus.m_data_o}), 32'h135);
      bus.data_in_bi[7:0] = 8'hEE;
      tick();
      check("basic_start", 32'({bus.m_start_o, bus.m_data_o}), 32'h135);
      wait_for(W_DONE);
      check("basic_done", 32'({bus.done_bo, bus.data_out_bo}), 32'h153);
      bus.req_bi = '0;
      tick();
      check("basic_release", 32'({bus.gnt_bo, bus.busy_o}), 32'h0);

      // Locked burst from requester 1, requester 0 waiting
      bus.data_in_bi[15:8] = 8'hFF;
      bus.lock_bi          = 4'b0010;
      bus.req_bi           = 4'b0011;
      wait_for(W_GNT);
      check("lock_first_gnt", 32'(bus.gnt_bo), 32'h2);
      gap_seen = 1'b0;
      for (int b = 0; b < 3; b++) begin
         wait_for(W_START);
         check($sformatf("lock_tx%0d", b), 32'(bus.m_data_o), 32'(lk_bytes[b]));
         for (int i = 0; i < 64 && !seen(W_DONE); i++) begin
            if (bus.gnt_bo !== 4'b0010 || bus.busy_o !== 1'b1) gap_seen = 1'b1;
            tick();
         end
         check($sformatf("lock_done%0d", b), 32'({bus.done_bo, bus.data_out_bo}),
               32'({4'b0010, lk_bytes[b]}));
         if (b < 2) begin
            bus.data_in_bi[15:8] = lk_bytes[b+1];
            tick();
            check($sformatf("lock_hold%0d", b), 32'({bus.busy_o, bus.gnt_bo}), 32'h12);
         end
      end
      check("lock_no_gap", 32'(gap_seen), 32'h0);
      bus.req_bi = 4'b0001;
      tick();
      check("lock_release", 32'(bus.gnt_bo), 32'h0);
      wait_for(W_GNT);
      check("lock_handoff", 32'(bus.gnt_bo), 32'h1);
      wait_for(W_DONE);
      bus.req_bi  = '0;
      bus.lock_bi = '0;
      tick();

      // Start never acknowledged
      slave_mode            = 1;
      bus.data_in_bi[23:16] = 8'h77;
      bus.data_in_bi[31:24] = 8'h78;
      bus.req_bi            = 4'b1100;
      wait_for(W_START);
      check("to_owner", 32'(bus.gnt_bo), 32'h4);
      n         = 0;
      done_seen = 1'b0;
      while (!seen(W_ERR) && n < 40) begin
         tick();
         n++;
         if (seen(W_DONE)) done_seen = 1'b1;
      end
      check("to_latency", 32'(n), 32'd16);
      check("to_err", 32'(bus.err_bo), 32'h4);
      check("to_no_done", 32'(done_seen), 32'h0);
      bus.req_bi = 4'b1000;
      slave_mode = 0;
      tick();
      check("to_next_gnt", 32'(bus.gnt_bo), 32'h8);
      wait_for(W_DONE);
      check("to_next_rx", 32'(bus.data_out_bo), 32'h87);
      bus.req_bi = '0;
      tick();

      // Master busy at request time
      slave_mode          = 2;
      bus.m_ready_i       = 1'b0;
      bus.data_in_bi[7:0] = 8'h5A;
      bus.req_bi          = 4'b0001;
      tick();
      tick();
      tick();
      check("busy_hold", 32'({bus.gnt_bo, bus.busy_o}), 32'h0);
      bus.m_ready_i = 1'b1;
      slave_mode    = 0;
      tick();
      check("busy_grant", 32'(bus.gnt_bo), 32'h1);
      wait_for(W_DONE);
      check("busy_rx", 32'(bus.data_out_bo), 32'hA5);
      bus.req_bi = '0;
      tick();

      // Reset while the byte is on the wire
      bus.data_in_bi[15:8] = 8'h3C;
      bus.req_bi           = 4'b0010;
      wait_for(W_START);
      check("rst_owner", 32'(bus.gnt_bo), 32'h2);
      tick();
      check("rst_in_flight", 32'(bus.busy_o), 32'h1);
      rst_n      = 1'b0;
      bus.req_bi = '0;
      tick();
      check("rst_mid_outputs", all_outs(), 32'h0);
      rst_n     = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (seen(W_DONE)) done_seen = 1'b1;
      end
      check("rst_no_done", 32'(done_seen), 32'h0);
      bus.data_in_bi[7:0]   = 8'h01;
      bus.data_in_bi[23:16] = 8'h02;
      bus.req_bi            = 4'b0101;
      wait_for(W_GNT);
      check("rst_rr_restart", 32'(bus.gnt_bo), 32'h1);
      wait_for(W_DONE);
      check("rst_rx0", 32'(bus.data_out_bo), 32'h10);
      bus.req_bi = 4'b0100;
      tick();
      wait_for(W_GNT);
      check("rst_pending_gnt", 32'(bus.gnt_bo), 32'h4);
      wait_for(W_DONE);
      check("rst_rx2", 32'(bus.data_out_bo), 32'h20);
      bus.req_bi = '0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
